// File: rtl/madd_sub_64_ctrl.sv
// rtl/madd_sub_64_ctrl.sv - sequencer for the 64-bit MADD/MSUB path: DSP48A1 low 48 bits, fabric high 16 bits
`timescale 1ns/1ps

module madd_sub_64_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_subtract,
  input  logic [63:0] in_acc,
  input  logic [63:0] in_prod,
  input  logic        flush,
  output logic [47:0] dsp_a_low,
  output logic [47:0] dsp_b_low,
  output logic        dsp_subtract,
  output logic        dsp_cea,
  output logic        dsp_ceb,
  output logic        dsp_cec,
  output logic        dsp_ced,
  output logic        dsp_ceopmode,
  output logic        dsp_cep,
  input  logic        dsp_carryout,
  input  logic [47:0] dsp_s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] acc_hi_q;
  logic [15:0] prod_hi_q;
  logic        sub_q;
  logic [15:0] hi16_q;
  logic [15:0] hi16_d;
  logic [15:0] hi_addend;
  logic        out_valid_q;
  logic        cep_q;
  logic        accept;

  // Gated by reset so no CE pulse or operand can leak while reset is held.
  assign in_ready = reset & (state_q == S_IDLE) & ~flush;
  assign accept   = in_ready & in_valid;

  assign dsp_cea      = accept;
  assign dsp_ceb      = accept;
  assign dsp_cec      = accept;
  assign dsp_ced      = accept;
  assign dsp_ceopmode = accept;
  assign dsp_a_low    = accept ? in_acc[47:0]  : 48'd0;
  assign dsp_b_low    = accept ? in_prod[47:0] : 48'd0;
  assign dsp_subtract = accept ? in_subtract   : 1'b0;

  // Subtract is acc + ~prod + carry; the slice's CARRYOUT already acts as the +1 / not-borrow.
  assign hi_addend = sub_q ? ~prod_hi_q : prod_hi_q;
  assign hi16_d    = acc_hi_q + hi_addend + {15'd0, dsp_carryout};

  assign dsp_cep    = cep_q;
  assign out_valid  = out_valid_q;
  assign out_result = {hi16_q, dsp_s};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_hi_q    <= 16'd0;
      prod_hi_q   <= 16'd0;
      sub_q       <= 1'b0;
      hi16_q      <= 16'd0;
      out_valid_q <= 1'b0;
      cep_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_hi_q  <= in_acc[63:48];
            prod_hi_q <= in_prod[63:48];
            sub_q     <= in_subtract;
            cep_q     <= 1'b1;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          hi16_q <= hi16_d;
          cep_q  <= 1'b0;
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          // Flush and out_ready both retire the result; flush just means nobody consumed it.
          if (flush || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          cep_q       <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
